// File: rtl/mac_checker_pkg.sv
// Shared control codes, frame field offsets, CRC constants and FSM encoding for the
// MII receive-side frame checker.
package mac_checker_pkg;

  localparam logic [7:0] CODE_IDLE     = 8'h07;
  localparam logic [7:0] CODE_START    = 8'hFB;
  localparam logic [7:0] CODE_TERM     = 8'hFD;
  localparam logic [7:0] CODE_PREAMBLE = 8'h55;
  localparam logic [7:0] CODE_SFD      = 8'hD5;

  localparam logic [15:0] OFF_SFD     = 16'd7;
  localparam logic [15:0] OFF_DA      = 16'd8;
  localparam logic [15:0] OFF_SA      = 16'd14;
  localparam logic [15:0] OFF_LT      = 16'd20;
  localparam logic [15:0] OFF_PAYLOAD = 16'd22;

  localparam logic [15:0] MAX_LEN_FIELD = 16'd1500;
  localparam logic [15:0] TYPE_MIN      = 16'h0600;
  localparam logic [15:0] MIN_PAYLOAD   = 16'd46;
  localparam logic [15:0] HDR_FCS_BYTES = 16'd18;

  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

  // Register kept MSB-first; bytes enter LSB-first, which gives the reflected CRC32.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ b[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_crc32_lanes.sv
// Folds up to NUM_LANES enabled bytes (lane 0 first) into a running CRC32.
// Purely combinational; disabled lanes pass the CRC through unchanged.
module mac_crc32_lanes import mac_checker_pkg::*; #(
  parameter int NUM_LANES = 8
) (
  input  logic [31:0]            crc_in,
  input  logic [8*NUM_LANES-1:0] data,
  input  logic [NUM_LANES-1:0]   lane_en,
  output logic [31:0]            crc_out
);

  logic [31:0] chain [NUM_LANES+1];

  assign chain[0] = crc_in;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign chain[k+1] = lane_en[k] ? crc32_byte(chain[k], data[8*k +: 8]) : chain[k];
  end

  assign crc_out = chain[NUM_LANES];

endmodule

// File: rtl/mac_frame_checker.sv
// Streaming MII frame checker: verdict and counters registered 1 cycle after the TERM word.
// No backpressure; i_data_valid low stalls and holds all state.
module mac_frame_checker import mac_checker_pkg::*; #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int          MIN_FRAME_SIZE = 64,
  parameter int          MAX_FRAME_SIZE = 1518,
  parameter logic [47:0] DST_ADDR_CODE  = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_ADDR_CODE  = 48'h123456789ABC,
  parameter int          CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  input  logic                  i_data_valid,
  output logic                  o_frame_done,
  output logic                  o_preamble_error,
  output logic                  o_header_error,
  output logic                  o_payload_error,
  output logic                  o_fcs_error,
  output logic [15:0]           o_frame_len,
  output logic [CNT_WIDTH-1:0]  o_good_frames,
  output logic [CNT_WIDTH-1:0]  o_bad_frames
);

  localparam int          NUM_LANES = DATA_WIDTH / 8;
  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME_SIZE);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_FRAME_SIZE);
  localparam logic [15:0] POS_CAP   = 16'(OFF_DA + MAX_LEN + 16'd1);

  state_t      state;
  logic [15:0] pos;
  logic [15:0] lt_q;
  logic        pre_q, hdr_q, pay_q;
  logic [31:0] crc_q;

  state_t                 st;
  logic [15:0]            p, lt, len, need;
  logic                   pre_e, hdr_e, pay_e;
  logic                   term_seen, clean_end;
  logic [NUM_LANES-1:0]   lane_en;
  logic [7:0]             b;
  logic                   c, is_term;
  int                     idx;
  logic [31:0]            crc_next;
  logic                   fcs_bad, any_err;

  mac_crc32_lanes #(.NUM_LANES(NUM_LANES)) u_crc (
    .crc_in  (crc_q),
    .data    (i_rx_data),
    .lane_en (lane_en),
    .crc_out (crc_next)
  );

  // Walk the word lane by lane; several FSM transitions may happen inside one word.
  always_comb begin
    st        = state;
    p         = pos;
    lt        = lt_q;
    pre_e     = pre_q;
    hdr_e     = hdr_q;
    pay_e     = pay_q;
    term_seen = 1'b0;
    clean_end = 1'b0;
    lane_en   = '0;
    b         = '0;
    c         = 1'b0;
    is_term   = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      b       = i_rx_data[8*k +: 8];
      c       = i_rx_ctrl[k];
      is_term = c && (b == CODE_TERM);
      if (!term_seen) begin
        case (st)
          IDLE: begin
            if (k == 0 && c && b == CODE_START) begin
              st    = PREAMBLE;
              p     = 16'd1;
              lt    = '0;
              pre_e = 1'b0;
              hdr_e = 1'b0;
              pay_e = 1'b0;
            end
          end
          PREAMBLE: begin
            if (is_term) begin
              pre_e     = 1'b1;
              term_seen = 1'b1;
            end else if (c || b != ((p == OFF_SFD) ? CODE_SFD : CODE_PREAMBLE)) begin
              pre_e = 1'b1;
              st    = DROP;
            end else begin
              if (p == OFF_SFD) st = HEADER;
              p = p + 16'd1;
            end
          end
          HEADER: begin
            if (is_term) begin
              hdr_e     = 1'b1;
              term_seen = 1'b1;
            end else if (c) begin
              pay_e = 1'b1;
              st    = DROP;
            end else begin
              lane_en[k] = 1'b1;
              idx        = int'(p - OFF_DA);
              if (p < OFF_SA) begin
                if (b != DST_ADDR_CODE[8*(5-idx) +: 8]) hdr_e = 1'b1;
              end else if (p < OFF_LT) begin
                if (b != SRC_ADDR_CODE[8*(11-idx) +: 8]) hdr_e = 1'b1;
              end else begin
                lt = {lt[7:0], b};
              end
              p = p + 16'd1;
              if (p == OFF_PAYLOAD) st = PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (is_term) begin
              term_seen = 1'b1;
              clean_end = 1'b1;
            end else if (c) begin
              pay_e = 1'b1;
              st    = DROP;
            end else if (p == POS_CAP - 16'd1) begin
              // this byte would be number MAX+1: oversize, stop counting at MAX+1
              pay_e = 1'b1;
              st    = DROP;
              p     = POS_CAP;
            end else begin
              lane_en[k] = 1'b1;
              p          = p + 16'd1;
            end
          end
          DROP: begin
            if (is_term) term_seen = 1'b1;
            else if (!c && p >= OFF_DA && p < POS_CAP) p = p + 16'd1;
          end
          default: st = IDLE;
        endcase
      end
    end

    len  = (p >= OFF_DA) ? (p - OFF_DA) : 16'd0;
    need = ((lt > MIN_PAYLOAD) ? lt : MIN_PAYLOAD) + HDR_FCS_BYTES;
    if (clean_end) begin
      if (len < MIN_LEN || len > MAX_LEN) pay_e = 1'b1;
      if (lt < TYPE_MIN && (lt > MAX_LEN_FIELD || len < need)) pay_e = 1'b1;
    end
  end

  assign fcs_bad = clean_end && (crc_next != CRC_RESIDUE);
  assign any_err = pre_e | hdr_e | pay_e | fcs_bad;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      pos              <= '0;
      lt_q             <= '0;
      pre_q            <= 1'b0;
      hdr_q            <= 1'b0;
      pay_q            <= 1'b0;
      crc_q            <= CRC_INIT;
      o_frame_done     <= 1'b0;
      o_preamble_error <= 1'b0;
      o_header_error   <= 1'b0;
      o_payload_error  <= 1'b0;
      o_fcs_error      <= 1'b0;
      o_frame_len      <= '0;
      o_good_frames    <= '0;
      o_bad_frames     <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_data_valid) begin
        state <= term_seen ? IDLE : st;
        pos   <= term_seen ? 16'd0 : p;
        crc_q <= term_seen ? CRC_INIT : crc_next;
        lt_q  <= lt;
        pre_q <= pre_e;
        hdr_q <= hdr_e;
        pay_q <= pay_e;
        if (term_seen) begin
          o_frame_done     <= 1'b1;
          o_preamble_error <= pre_e;
          o_header_error   <= hdr_e;
          o_payload_error  <= pay_e;
          o_fcs_error      <= fcs_bad;
          o_frame_len      <= len;
          if (any_err) begin
            if (o_bad_frames != '1) o_bad_frames <= o_bad_frames + 1'b1;
          end else begin
            if (o_good_frames != '1) o_good_frames <= o_good_frames + 1'b1;
          end
        end
      end
    end
  end

endmodule
